mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage of the 5-stage RISC-V pipeline, sitting between the EX/MEM pipeline register and `MEM_WB`. It converts load/store controls from EX/MEM into a request/acknowledge transaction on a variable-latency data memory, and formats byte/half/word load data. While a transaction is in flight it stalls the upstream pipeline and masks register write-back so `MEM_WB` captures only completed results.

## Interface
- `ADDR_W`, default 32: data address width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `MemRead_i`  in  1  load in MEM stage (from EX/MEM).
- `MemWrite_i`  in  1  store in MEM stage.
- `RegWrite_i`  in  1  write-back enable of MEM-stage instruction.
- `funct3_i`  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `Addr_i`  in  ADDR_W  byte address (ALU result).
- `WriteData_i`  in  32  store data, right-aligned.
- `RegWrite_o`  out  1  gated write enable to `MEM_WB.RegWrite_i`.
- `ReadData_o`  out  32  formatted load data to `MEM_WB.ReadData_i`.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- `misalign_o`  out  1  one-cycle pulse: misaligned access dropped.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-shifted store data.
- `dmem_ack_i`  in  1  memory done; read data valid same cycle.
- `dmem_rdata_i`  in  32  read word.

## Operation
- `access` = (`MemRead_i` | `MemWrite_i`) & aligned. Aligned: w needs Addr[1:0]=0, h/hu Addr[0]=0, b/bu always.
- FSM states IDLE, REQ, DONE.
- IDLE: if `access`, latch addr/we/be/wdata/funct3/Addr[1:0], go REQ. Misaligned access: stay IDLE, `misalign_o`=1, no request.
- REQ: `dmem_req_o`=1, all dmem outputs from latched registers, stable until ack. On `dmem_ack_i`=1: for loads, latch formatted `dmem_rdata_i` into result reg; go DONE.
- DONE: unconditional return to IDLE next cycle.
- `stall_o` = (IDLE & `access`) | REQ. Combinational.
- `RegWrite_o` = `RegWrite_i` & ~`stall_o` & ~misaligned-load.
- `ReadData_o` = result reg in DONE, else 0.
- Store lanes: sb → be = 0001<<Addr[1:0], data byte replicated; sh → be = 0011<<Addr[1:0], half replicated; sw → be 1111.
- Load format: select lane by Addr[1:0]; b/h sign-extend, bu/hu zero-extend, w pass-through.
- Non-memory instructions: stall_o=0, RegWrite passes through, no request.

## Timing
- Reset (async): state IDLE; `dmem_req_o`, `dmem_we_o`, `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o`, result reg, `misalign_o` all 0. Reset mid-REQ drops the request immediately; memory tolerates abandoned requests.
- Minimum MEM-stage occupancy for a memory instruction: 3 cycles (IDLE, REQ with ack in first cycle, DONE). Each ack-less REQ cycle adds 1.
- `MEM_WB` captures the valid result at the end of the DONE cycle; upstream advances on the same edge.
- `dmem_ack_i` outside REQ is ignored.
- Back-to-back memory instructions: the second is evaluated in IDLE on the cycle after DONE; no overlap.
- `misalign_o` lasts exactly 1 cycle; the instruction retires without stall.

## Structure
- Shared package `mem_pkg`: funct3 size codes, FSM state encoding, `ADDR_W` default.
- Sub-module `mem_load_align`: combinational lane select plus sign/zero extension, reused by a future cache path.

## Test plan
- Reset during REQ with addr 0x100 → `dmem_req_o` falls same cycle, state IDLE, all outputs 0.
- lw 0x0000_0010, ack after 2 wait cycles, rdata 0xDEADBEEF → stall 4 cycles, `ReadData_o`=0xDEADBEEF in DONE, RegWrite_o=1 only in DONE.
- lb addr 0x13, rdata 0x80xxxxxx → ReadData 0xFFFFFF80; lbu → 0x00000080; lh addr 0x12, rdata 0x8001xxxx → 0xFFFF8001.
- sb addr 0x21, data 0x000000AB → be 0010, wdata 0xABABABAB, we=1, addr 0x20.
- lw addr 0x02 → no request, `misalign_o` one cycle, RegWrite_o=0, no stall.
- Two consecutive sw, ack in first REQ cycle → each occupies 3 cycles, requests never overlap, stray ack in IDLE ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: access-size codes,
// FSM encoding and the store-lane helpers.
package mem_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // funct3[1:0] carries the size; bit 2 only selects zero-extension on loads.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return off == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the datum into every lane lets the byte enables alone pick the target.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half from a memory word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX/MEM load/store controls into a req/ack transaction on a
// variable-latency data memory, stalling upstream until the result is ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic [31:0]       WriteData_i,
  output logic              RegWrite_o,
  output logic [31:0]       ReadData_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       result_q, result_d;

  logic        mem_op, aligned, access, misaligned, in_idle;
  logic [31:0] load_data;

  assign mem_op     = MemRead_i | MemWrite_i;
  assign aligned    = is_aligned(funct3_i, Addr_i[1:0]);
  assign access     = mem_op & aligned;
  assign in_idle    = (state_q == ST_IDLE);
  assign misaligned = in_idle & mem_op & ~aligned;

  // Formatting uses the latched size/offset so it is independent of EX/MEM.
  mem_load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = {Addr_i[ADDR_W-1:2], 2'b00};
          be_d    = lane_be(funct3_i, Addr_i[1:0]);
          wdata_d = MemWrite_i ? lane_wdata(funct3_i, WriteData_i) : 32'd0;
          f3_d    = funct3_i;
          off_d   = Addr_i[1:0];
        end
      end
      ST_REQ: begin
        if (dmem_ack_i) begin
          state_d  = ST_DONE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          be_d     = 4'd0;
          wdata_d  = 32'd0;
          result_d = we_q ? 32'd0 : load_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      result_q <= result_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  assign stall_o    = (in_idle & access) | (state_q == ST_REQ);
  assign misalign_o = misaligned;
  // A dropped load must not write back whatever sits in MEM_WB.ReadData.
  assign RegWrite_o = RegWrite_i & ~stall_o & ~(misaligned & MemRead_i);
  assign ReadData_o = (state_q == ST_DONE) ? result_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors against a small
// memory responder, expected load results held in a queue until DONE.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] Addr_i, WriteData_i;
  logic        RegWrite_o, stall_o, misalign_o;
  logic [31:0] ReadData_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .funct3_i(funct3_i), .Addr_i(Addr_i), .WriteData_i(WriteData_i),
    .RegWrite_o(RegWrite_o), .ReadData_o(ReadData_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  typedef struct {
    logic        rd, wr, rw;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          wt;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_read;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; funct3_i = 3'b000;
    Addr_i = 0; WriteData_i = 0; dmem_ack_i = 0;
  endtask

  // Entered at posedge+1; leaves at posedge+1 with the DUT back in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int  stalls = 0;
    int  reqs   = 0;
    bit  done   = 0;
    logic [31:0] exp_rd;
    MemRead_i = v.rd; MemWrite_i = v.wr; RegWrite_i = v.rw;
    funct3_i = v.f3; Addr_i = v.addr; WriteData_i = v.wd; dmem_ack_i = 0;
    if (v.mis) begin
      @(negedge clk_i);
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
      chk("mis_regwrite", {31'd0, RegWrite_o}, {31'd0, v.rd ? 1'b0 : v.rw});
      @(posedge clk_i); #1;
      idle_inputs();
      @(negedge clk_i);
      chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
      chk("mis_no_req", {31'd0, dmem_req_o}, 32'd0);
      @(posedge clk_i); #1;
      $display("vec %0d: misaligned f3=%b addr=%h dropped", idx, v.f3, v.addr);
      return;
    end
    exp_q.push_back(v.e_read);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (dmem_req_o) begin
        chk("req_addr", dmem_addr_o, v.e_addr);
        chk("req_we", {31'd0, dmem_we_o}, {31'd0, v.e_we});
        chk("req_be", {28'd0, dmem_be_o}, {28'd0, v.e_be});
        chk("req_wdata", dmem_wdata_o, v.e_wdata);
        if (reqs == v.wt) begin
          dmem_ack_i = 1; dmem_rdata_i = v.rdata;
        end else begin
          dmem_ack_i = 0; dmem_rdata_i = $urandom;
        end
        reqs++;
      end else begin
        dmem_ack_i = 0; dmem_rdata_i = $urandom;
      end
      if (stall_o) begin
        stalls++;
        chk("regwrite_masked", {31'd0, RegWrite_o}, 32'd0);
      end else begin
        done = 1;
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk("readdata", ReadData_o, exp_rd);
        chk("regwrite_done", {31'd0, RegWrite_o}, {31'd0, v.rw});
        chk("stall_cycles", stalls, v.wt + 2);
        chk("req_dropped", {31'd0, dmem_req_o}, 32'd0);
      end
      @(posedge clk_i); #1;
    end
    if (!done) chk("timeout_done", 32'd0, 32'd1);
    dmem_ack_i = 0;
    $display("vec %0d: f3=%b addr=%h we=%0b stalls=%0d read=%h", idx, v.f3, v.addr, v.wr, stalls, ReadData_o);
  endtask

  initial begin
    //          rd wr rw f3      addr          wd            rdata        wt mis e_addr        e_be     e_wdata       we e_read
    vecs[0]  = '{1, 0, 1, 3'b010, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 2, 0, 32'h10, 4'b1111, 32'h0,        0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 1, 3'b000, 32'h0000_0013, 32'h0,        32'h80123456, 0, 0, 32'h10, 4'b1000, 32'h0,        0, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 1, 3'b100, 32'h0000_0013, 32'h0,        32'h80123456, 0, 0, 32'h10, 4'b1000, 32'h0,        0, 32'h00000080};
    vecs[3]  = '{1, 0, 1, 3'b001, 32'h0000_0012, 32'h0,        32'h80011234, 1, 0, 32'h10, 4'b1100, 32'h0,        0, 32'hFFFF8001};
    vecs[4]  = '{1, 0, 1, 3'b101, 32'h0000_0012, 32'h0,        32'h80011234, 0, 0, 32'h10, 4'b1100, 32'h0,        0, 32'h00008001};
    vecs[5]  = '{1, 0, 1, 3'b000, 32'h0000_0010, 32'h0,        32'h1234567F, 0, 0, 32'h10, 4'b0001, 32'h0,        0, 32'h0000007F};
    vecs[6]  = '{1, 0, 1, 3'b001, 32'h0000_0014, 32'h0,        32'h7FFF8765, 0, 0, 32'h14, 4'b0011, 32'h0,        0, 32'hFFFF8765};
    vecs[7]  = '{0, 1, 0, 3'b000, 32'h0000_0021, 32'h000000AB, 32'h0,        0, 0, 32'h20, 4'b0010, 32'hABABABAB, 1, 32'h0};
    vecs[8]  = '{0, 1, 0, 3'b001, 32'h0000_0022, 32'h0000BEEF, 32'h0,        1, 0, 32'h20, 4'b1100, 32'hBEEFBEEF, 1, 32'h0};
    vecs[9]  = '{0, 1, 0, 3'b010, 32'h0000_0024, 32'h12345678, 32'h0,        0, 0, 32'h24, 4'b1111, 32'h12345678, 1, 32'h0};
    vecs[10] = '{0, 1, 0, 3'b010, 32'h0000_0028, 32'hCAFEF00D, 32'h0,        0, 0, 32'h28, 4'b1111, 32'hCAFEF00D, 1, 32'h0};
    vecs[11] = '{1, 0, 1, 3'b010, 32'h0000_0002, 32'h0,        32'h0,        0, 1, 32'h0,  4'b0000, 32'h0,        0, 32'h0};
    vecs[12] = '{1, 0, 1, 3'b001, 32'h0000_0011, 32'h0,        32'h0,        0, 1, 32'h0,  4'b0000, 32'h0,        0, 32'h0};
    vecs[13] = '{0, 1, 0, 3'b010, 32'h0000_0006, 32'h55555555, 32'h0,        0, 1, 32'h0,  4'b0000, 32'h0,        0, 32'h0};

    rst_i = 1; dmem_rdata_i = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_readdata", ReadData_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    $display("reset: outputs checked");
    rst_i = 0;
    @(posedge clk_i); #1;

    // Table: vectors 9 and 10 are back-to-back stores with no idle gap.
    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Non-memory instruction with a stray ack: no request, write-back passes.
    idle_inputs();
    RegWrite_i = 1; dmem_ack_i = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk("nonmem_stall", {31'd0, stall_o}, 32'd0);
      chk("nonmem_regwrite", {31'd0, RegWrite_o}, 32'd1);
      chk("nonmem_req", {31'd0, dmem_req_o}, 32'd0);
      chk("nonmem_readdata", ReadData_o, 32'd0);
      @(posedge clk_i); #1;
    end
    idle_inputs();
    $display("non-memory with stray ack: no request");

    // Reset while a request to 0x100 is outstanding.
    MemRead_i = 1; RegWrite_i = 1; funct3_i = 3'b010; Addr_i = 32'h100;
    @(negedge clk_i);
    chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
    chk("pre_rst_addr", dmem_addr_o, 32'h100);
    rst_i = 1;
    idle_inputs();
    #1;
    chk("midreq_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("midreq_rst_addr", dmem_addr_o, 32'd0);
    chk("midreq_rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("midreq_rst_readdata", ReadData_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("post_rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
    $display("reset mid-REQ: request dropped");

    @(posedge clk_i); #1;
    run_vec(99, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
